mesh_router_param: RTL and testbench

//  5-port wormhole mesh router. Each input port has its own parametrised flit FIFO, and the router uses XY

---
 rtl/router_pkg.sv | 64 ++++++
 rtl/noc_input_fifo.sv | 83 ++++++++
 rtl/mesh_router_param.sv | 187 ++++++++++++++++++
 tb/tb_mesh_router_param.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and helpers for the 5-port wormhole mesh router.
//               Holds the port map, flit type encoding, flit field offsets
//               and the round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int N_PORTS = 5;

  // Output/input port index; NORTH is +Y, EAST is +X
  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_EAST  = 3'd2,
    P_SOUTH = 3'd3,
    P_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Flit layout from the MSB down: type[2], dst_x[X_W], dst_y[Y_W], payload
  function automatic int type_lsb(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int dst_x_lsb(input int flit_w, input int x_w);
    return flit_w - 2 - x_w;
  endfunction

  function automatic int dst_y_lsb(input int flit_w, input int x_w, input int y_w);
    return flit_w - 2 - x_w - y_w;
  endfunction

  // First requester strictly after 'last', wrapping from N_PORTS-1 back to 0
  function automatic rr_pick_t rr_pick(input logic [N_PORTS-1:0] req, input logic [2:0] last);
    rr_pick_t r;
    int       idx;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(last) + k) % N_PORTS;
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = 3'(idx);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_input_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_fifo
// Description : Per-port input flit FIFO with registered on/off back-pressure
//               and a sticky overflow flag for flits that hit a full FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_input_fifo #(
  parameter int FLIT_W     = 34,
  parameter int FIFO_DEPTH = 8,
  parameter int OFF_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] din_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] front_o,
  output logic              empty_o,
  output logic              on_off_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       cnt_q;
  logic [AW:0]       cnt_d;
  logic              on_off_q;
  logic              on_off_d;
  logic              ovf_q;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop_ok     = pop_i && !empty_o;
  // A full FIFO still accepts a flit when a pop frees a slot in the same cycle
  assign push_ok    = push_i && (!full || pop_ok);
  assign front_o    = mem_q[rd_q];
  assign on_off_o   = on_off_q;
  assign overflow_o = ovf_q;

  // Occupancy after this cycle's push/pop, and the on/off level it implies
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    on_off_d = (FIFO_DEPTH - int'(cnt_d)) > OFF_THRESH;
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // Pointers, occupancy, registered on/off and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      on_off_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q    <= cnt_d;
      on_off_q <= on_off_d;
      ovf_q    <= ovf_q | (push_i && full && !pop_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_router_param.sv
`default_nettype none
// ============================================================================
// Module      : mesh_router_param
// Description : 5-port wormhole mesh router with XY routing, per-input flit
//               FIFOs, per-output round-robin allocators that lock to one
//               input per packet, and on/off flow control both ways.
//               Optional per-output flit counters under ROUTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_router_param
  import router_pkg::*;
#(
  parameter int FLIT_W     = 34,
  parameter int X_W        = 3,
  parameter int Y_W        = 3,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int OFF_THRESH = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_PORTS-1:0]               i_valid,
  input  logic [N_PORTS-1:0][FLIT_W-1:0]   i_flit,
  output logic [N_PORTS-1:0]               o_on_off,
  output logic [N_PORTS-1:0]               o_valid,
  output logic [N_PORTS-1:0][FLIT_W-1:0]   o_flit,
  input  logic [N_PORTS-1:0]               i_on_off,
  output logic [N_PORTS-1:0]               o_overflow,
  output logic [N_PORTS-1:0][31:0]         o_flit_cnt
);

  localparam int TY_LSB = type_lsb(FLIT_W);
  localparam int DX_LSB = dst_x_lsb(FLIT_W, X_W);
  localparam int DY_LSB = dst_y_lsb(FLIT_W, X_W, Y_W);

  logic [N_PORTS-1:0][FLIT_W-1:0]  front;
  logic [N_PORTS-1:0]              empty;
  logic [N_PORTS-1:0]              pop;
  logic [N_PORTS-1:0][1:0]         ftype;
  logic [N_PORTS-1:0][X_W-1:0]     dst_x;
  logic [N_PORTS-1:0][Y_W-1:0]     dst_y;
  logic [N_PORTS-1:0][2:0]         route;
  logic [N_PORTS-1:0][2:0]         route_q;
  logic [N_PORTS-1:0][N_PORTS-1:0] req;
  rr_pick_t                        pick [N_PORTS];
  logic [N_PORTS-1:0]              gnt;
  logic [N_PORTS-1:0][2:0]         gidx;
  logic [N_PORTS-1:0][FLIT_W-1:0]  gflit;
  logic [N_PORTS-1:0][1:0]         gtype;
  logic [N_PORTS-1:0]              lock_q;
  logic [N_PORTS-1:0][2:0]         owner_q;
  logic [N_PORTS-1:0][2:0]         ptr_q;
  logic [N_PORTS-1:0]              valid_q;
  logic [N_PORTS-1:0][FLIT_W-1:0]  flit_q;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in_fifo
      noc_input_fifo #(
        .FLIT_W     (FLIT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .OFF_THRESH (OFF_THRESH)
      ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (i_valid[gi]),
        .din_i      (i_flit[gi]),
        .pop_i      (pop[gi]),
        .front_o    (front[gi]),
        .empty_o    (empty[gi]),
        .on_off_o   (o_on_off[gi]),
        .overflow_o (o_overflow[gi])
      );
      assign ftype[gi] = front[gi][TY_LSB +: 2];
      assign dst_x[gi] = front[gi][DX_LSB +: X_W];
      assign dst_y[gi] = front[gi][DY_LSB +: Y_W];
    end
  endgenerate

  // XY route of each FIFO front; head flits compute it, others reuse the latch
  always_comb begin
    route = route_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if ((ftype[i] == FT_HEAD) || (ftype[i] == FT_HEADTAIL)) begin
        if (dst_x[i] > X_W'(MY_X))      route[i] = P_EAST;
        else if (dst_x[i] < X_W'(MY_X)) route[i] = P_WEST;
        else if (dst_y[i] > Y_W'(MY_Y)) route[i] = P_NORTH;
        else if (dst_y[i] < Y_W'(MY_Y)) route[i] = P_SOUTH;
        else                            route[i] = P_LOCAL;
      end
    end
  end

  // Per-output allocation: lock owner only when locked, else round-robin
  always_comb begin
    req   = '0;
    gnt   = '0;
    gidx  = '0;
    gflit = '0;
    gtype = '0;
    pop   = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        req[o][i] = !empty[i] && (route[i] == 3'(o));
      end
      pick[o] = rr_pick(req[o], ptr_q[o]);
      if (i_on_off[o]) begin
        if (lock_q[o]) begin
          gnt[o]  = req[o][owner_q[o]];
          gidx[o] = owner_q[o];
        end else begin
          gnt[o]  = pick[o].found;
          gidx[o] = pick[o].idx;
        end
      end
      gflit[o] = front[gidx[o]];
      gtype[o] = gflit[o][TY_LSB +: 2];
      // Each input routes to exactly one output, so at most one pop per input
      if (gnt[o]) pop[gidx[o]] = 1'b1;
    end
  end

  // Lock, owner and round-robin pointer per output; route latch per input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      route_q <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (gnt[o]) begin
          case (gtype[o])
            FT_HEAD: begin
              lock_q[o]  <= 1'b1;
              owner_q[o] <= gidx[o];
              ptr_q[o]   <= gidx[o];
            end
            FT_HEADTAIL: ptr_q[o]  <= gidx[o];
            FT_TAIL:     lock_q[o] <= 1'b0;
            default:     lock_q[o] <= lock_q[o];
          endcase
        end
      end
      for (int i = 0; i < N_PORTS; i++) begin
        if (pop[i]) route_q[i] <= route[i];
      end
    end
  end

  // Switch traversal: granted flit registered onto its output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      flit_q  <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        valid_q[o] <= gnt[o];
        flit_q[o]  <= gnt[o] ? gflit[o] : '0;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_flit  = flit_q;

`ifdef ROUTER_STATS_EN
  logic [N_PORTS-1:0][31:0] cnt_q;

  // Forwarded-flit counter per output, free-running with natural wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        cnt_q[o] <= cnt_q[o] + 32'(valid_q[o]);
      end
    end
  end

  assign o_flit_cnt = cnt_q;
`else
  assign o_flit_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesh_router_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_router_param
// Description : Self-checking bench for mesh_router_param at MY=(1,1).
//               Directed scenarios plus randomized packet rounds checked
//               against a packet-level model (XY destination port, packets
//               contiguous and intact on each output).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_router_param;

  localparam int FW = 34;
  localparam int NP = 5;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NP-1:0]          i_valid;
  logic [NP-1:0][FW-1:0]  i_flit;
  logic [NP-1:0]          o_on_off;
  logic [NP-1:0]          o_valid;
  logic [NP-1:0][FW-1:0]  o_flit;
  logic [NP-1:0]          i_on_off;
  logic [NP-1:0]          o_overflow;
  logic [NP-1:0][31:0]    o_flit_cnt;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [FW-1:0] cap_f [NP][$];
  int            cap_c [NP][$];

  mesh_router_param #(
    .FLIT_W(FW), .X_W(3), .Y_W(3), .MY_X(1), .MY_Y(1),
    .FIFO_DEPTH(8), .OFF_THRESH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_flit(i_flit),
    .o_on_off(o_on_off), .o_valid(o_valid), .o_flit(o_flit),
    .i_on_off(i_on_off), .o_overflow(o_overflow), .o_flit_cnt(o_flit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (reset_n && o_valid[o]) begin
        cap_f[o].push_back(o_flit[o]);
        cap_c[o].push_back(cyc);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y, input logic [25:0] pl);
    logic [2:0] xx;
    logic [2:0] yy;
    xx = 3'(x);
    yy = 3'(y);
    return {t, xx, yy, pl};
  endfunction

  // Destination port under XY order, from this router at (1,1)
  function automatic int xy_port(input int x, input int y);
    if (x > 1) return 2;
    if (x < 1) return 4;
    if (y > 1) return 1;
    if (y < 1) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ROUTER_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic clear_caps();
    for (int o = 0; o < NP; o++) begin
      cap_f[o].delete();
      cap_c[o].delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid  = '0;
    i_flit   = '0;
    i_on_off = '1;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    clear_caps();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (o_valid !== 5'h00) begin errors++; $display("FAIL reset_valid got %h want 00", o_valid); end
    vectors++; if (o_flit !== '0) begin errors++; $display("FAIL reset_flit got %h want 0", o_flit); end
    vectors++; if (o_on_off !== 5'h1f) begin errors++; $display("FAIL reset_on_off got %h want 1f", o_on_off); end
    vectors++; if (o_overflow !== 5'h00) begin errors++; $display("FAIL reset_overflow got %h want 00", o_overflow); end
    vectors++; if (o_flit_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", o_flit_cnt); end
  endtask

  task automatic test_unicast();
    logic [FW-1:0] f [3];
    int t0;
    do_reset();
    f[0] = mk(2'b10, 3, 1, 26'($urandom));
    f[1] = mk(2'b00, 0, 0, 26'($urandom));
    f[2] = mk(2'b01, 0, 0, 26'($urandom));
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      i_valid[0] = 1'b1; i_flit[0] = f[k];
      tick();
    end
    i_valid = '0;
    repeat (8) tick();
    vectors++;
    if (cap_f[2].size() != 3) begin errors++; $display("FAIL uni_count got %0d want 3", cap_f[2].size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < cap_f[2].size()) begin
        vectors++;
        if (cap_f[2][k] !== f[k] || cap_c[2][k] != t0 + 2 + k) begin
          errors++;
          $display("FAIL uni_flit%0d got %h@%0d want %h@%0d", k, cap_f[2][k], cap_c[2][k], f[k], t0 + 2 + k);
        end
      end
    end
    vectors++;
    if (cap_f[0].size() + cap_f[1].size() + cap_f[3].size() + cap_f[4].size() != 0) begin
      errors++; $display("FAIL uni_stray got %0d extra flits want 0", cap_f[0].size() + cap_f[1].size() + cap_f[3].size() + cap_f[4].size());
    end
    vectors++;
    if (o_flit_cnt[2] !== exp_cnt(3)) begin errors++; $display("FAIL uni_cnt got %0d want %0d", o_flit_cnt[2], exp_cnt(3)); end
  endtask

  task automatic test_contention();
    logic [FW-1:0] p1 [3];
    logic [FW-1:0] p3 [3];
    logic [FW-1:0] exp [$];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      p1[k] = mk((k == 0) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00, 1, 1, 26'($urandom));
      p3[k] = mk((k == 0) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00, 1, 1, 26'($urandom));
    end
    for (int k = 0; k < 3; k++) exp.push_back(p1[k]);
    for (int k = 0; k < 3; k++) exp.push_back(p3[k]);
    for (int k = 0; k < 3; k++) begin
      i_valid = 5'b01010; i_flit[1] = p1[k]; i_flit[3] = p3[k];
      tick();
    end
    i_valid = '0;
    repeat (12) tick();
    vectors++;
    if (cap_f[0].size() != 6) begin errors++; $display("FAIL cont_count got %0d want 6", cap_f[0].size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < cap_f[0].size()) begin
        vectors++;
        if (cap_f[0][k] !== exp[k]) begin errors++; $display("FAIL cont_flit%0d got %h want %h", k, cap_f[0][k], exp[k]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] f [9];
    int occ;
    do_reset();
    i_on_off[2] = 1'b0;
    f[0] = mk(2'b10, 3, 1, 26'($urandom));
    for (int k = 1; k < 9; k++) f[k] = mk((k == 7) ? 2'b01 : 2'b00, 0, 0, 26'($urandom));
    for (int k = 0; k < 9; k++) begin
      i_valid[0] = 1'b1; i_flit[0] = f[k];
      tick();
      occ = (k + 1 > 8) ? 8 : k + 1;
      vectors++;
      if (o_on_off[0] !== ((8 - occ) > 2)) begin errors++; $display("FAIL stall_onoff%0d got %b want %b", k + 1, o_on_off[0], (8 - occ) > 2); end
      vectors++;
      if (o_overflow[0] !== (k + 1 > 8)) begin errors++; $display("FAIL stall_ovf%0d got %b want %b", k + 1, o_overflow[0], k + 1 > 8); end
    end
    i_valid = '0;
    repeat (3) tick();
    vectors++;
    if (cap_f[2].size() != 0) begin errors++; $display("FAIL stall_blocked got %0d flits want 0", cap_f[2].size()); end
    i_on_off[2] = 1'b1;
    repeat (15) tick();
    vectors++;
    if (cap_f[2].size() != 8) begin errors++; $display("FAIL stall_drain got %0d want 8", cap_f[2].size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < cap_f[2].size()) begin
        vectors++;
        if (cap_f[2][k] !== f[k]) begin errors++; $display("FAIL stall_flit%0d got %h want %h", k, cap_f[2][k], f[k]); end
      end
    end
    vectors++;
    if (o_overflow[0] !== 1'b1 || o_on_off[0] !== 1'b1) begin
      errors++; $display("FAIL stall_after got ovf=%b on=%b want ovf=1 on=1", o_overflow[0], o_on_off[0]);
    end
    vectors++;
    if (o_flit_cnt[2] !== exp_cnt(8)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", o_flit_cnt[2], exp_cnt(8)); end
  endtask

  task automatic test_headtail_rr();
    logic [FW-1:0] f [NP];
    int t0;
    do_reset();
    for (int i = 0; i < NP; i++) f[i] = mk(2'b11, 1, 1, 26'($urandom));
    t0 = cyc;
    i_valid = 5'b11110;
    for (int i = 1; i < NP; i++) i_flit[i] = f[i];
    tick();
    i_valid = '0;
    repeat (8) tick();
    vectors++;
    if (cap_f[0].size() != 4) begin errors++; $display("FAIL ht_count got %0d want 4", cap_f[0].size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < cap_f[0].size()) begin
        vectors++;
        if (cap_f[0][k] !== f[k + 1] || cap_c[0][k] != t0 + 2 + k) begin
          errors++;
          $display("FAIL ht_order%0d got %h@%0d want %h@%0d", k, cap_f[0][k], cap_c[0][k], f[k + 1], t0 + 2 + k);
        end
      end
    end
    // Pointer now on input 4: next pick wraps to input 0 before input 1
    clear_caps();
    f[0] = mk(2'b11, 1, 1, 26'($urandom));
    f[1] = mk(2'b11, 1, 1, 26'($urandom));
    i_valid = 5'b00011; i_flit[0] = f[0]; i_flit[1] = f[1];
    tick();
    i_valid = '0;
    repeat (6) tick();
    vectors++;
    if (cap_f[0].size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", cap_f[0].size()); end
    else begin
      vectors++;
      if (cap_f[0][0] !== f[0] || cap_f[0][1] !== f[1]) begin
        errors++; $display("FAIL wrap_order got %h,%h want %h,%h", cap_f[0][0], cap_f[0][1], f[0], f[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f [2];
    do_reset();
    i_valid[0] = 1'b1; i_flit[0] = mk(2'b10, 3, 1, 26'($urandom)); tick();
    i_flit[0] = mk(2'b00, 0, 0, 26'($urandom)); tick();
    i_flit[0] = mk(2'b00, 0, 0, 26'($urandom));
    #2;
    vectors++;
    if (o_valid[2] !== 1'b1) begin errors++; $display("FAIL mid_pre got valid2=%b want 1", o_valid[2]); end
    reset_n = 1'b0;
    i_valid = '0;
    #1;
    vectors++;
    if (o_valid !== '0 || o_flit !== '0 || o_on_off !== 5'h1f || o_overflow !== '0 || o_flit_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%h on=%h ovf=%h want v=00 on=1f ovf=00 flit/cnt=0", o_valid, o_on_off, o_overflow);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    clear_caps();
    f[0] = mk(2'b10, 0, 1, 26'($urandom));
    f[1] = mk(2'b01, 0, 0, 26'($urandom));
    for (int k = 0; k < 2; k++) begin
      i_valid[0] = 1'b1; i_flit[0] = f[k];
      tick();
    end
    i_valid = '0;
    repeat (8) tick();
    vectors++;
    if (cap_f[4].size() != 2 || cap_f[2].size() != 0) begin
      errors++; $display("FAIL mid_new got W=%0d E=%0d flits want W=2 E=0", cap_f[4].size(), cap_f[2].size());
    end else begin
      vectors++;
      if (cap_f[4][0] !== f[0] || cap_f[4][1] !== f[1]) begin
        errors++; $display("FAIL mid_new_flits got %h,%h want %h,%h", cap_f[4][0], cap_f[4][1], f[0], f[1]);
      end
    end
  endtask

  task automatic test_xy();
    int dx [5]  = '{0, 1, 1, 1, 2};
    int dy [5]  = '{2, 0, 1, 2, 0};
    int ep [5]  = '{4, 3, 0, 1, 2};
    logic [FW-1:0] f [5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      f[k] = mk(2'b11, dx[k], dy[k], 26'($urandom));
      i_valid[0] = 1'b1; i_flit[0] = f[k];
      tick();
    end
    i_valid = '0;
    repeat (8) tick();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (cap_f[ep[k]].size() != 1 || cap_f[ep[k]][0] !== f[k]) begin
        errors++;
        $display("FAIL xy_dst(%0d,%0d) got %0d flits on port %0d want 1 flit %h", dx[k], dy[k], cap_f[ep[k]].size(), ep[k], f[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] pk [NP][4];
    int len [NP];
    int dst [NP];
    int tot [NP];
    logic [NP-1:0] seen;
    logic [NP-1:0] want;
    int idx;
    int s;
    bit ok;
    do_reset();
    for (int o = 0; o < NP; o++) tot[o] = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NP; i++) begin
        int x;
        int y;
        len[i] = int'($urandom_range(1, 4));
        x = int'($urandom_range(0, 3));
        y = int'($urandom_range(0, 3));
        dst[i] = xy_port(x, y);
        tot[dst[i]] += len[i];
        for (int k = 0; k < 4; k++) begin
          logic [1:0] t;
          logic [25:0] pl;
          if (len[i] == 1)           t = 2'b11;
          else if (k == 0)           t = 2'b10;
          else if (k == len[i] - 1)  t = 2'b01;
          else                       t = 2'b00;
          pl = {23'($urandom), 3'(i)};
          pk[i][k] = mk(t, x, y, pl);
        end
      end
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < NP; i++) begin
          i_valid[i] = (k < len[i]);
          i_flit[i]  = pk[i][k];
        end
        tick();
      end
      i_valid = '0;
      repeat (30) tick();
      for (int o = 0; o < NP; o++) begin
        logic [FW-1:0] h;
        seen = '0;
        want = '0;
        for (int i = 0; i < NP; i++) if (dst[i] == o) want[i] = 1'b1;
        idx = 0;
        while (idx < cap_f[o].size()) begin
          h  = cap_f[o][idx];
          s  = int'(h[2:0]);
          ok = (s < NP);
          if (ok) ok = !seen[s] && want[s];
          if (ok) begin
            for (int k = 0; k < len[s]; k++) begin
              if (idx + k >= cap_f[o].size()) ok = 1'b0;
              else if (cap_f[o][idx + k] !== pk[s][k]) ok = 1'b0;
            end
          end
          vectors++;
          if (!ok) begin
            errors++;
            $display("FAIL rand_pkt r%0d out%0d got head %h at %0d want an intact packet from a source routed here", r, o, h, idx);
            break;
          end
          seen[s] = 1'b1;
          idx += len[s];
        end
        vectors++;
        if (seen !== want) begin errors++; $display("FAIL rand_set r%0d out%0d got srcs %b want %b", r, o, seen, want); end
      end
      clear_caps();
    end
    for (int o = 0; o < NP; o++) begin
      vectors++;
      if (o_flit_cnt[o] !== exp_cnt(tot[o])) begin errors++; $display("FAIL rand_cnt out%0d got %0d want %0d", o, o_flit_cnt[o], exp_cnt(tot[o])); end
    end
    vectors++;
    if (o_overflow !== '0) begin errors++; $display("FAIL rand_ovf got %h want 00", o_overflow); end
  endtask

  initial begin
    reset_n  = 1'b0;
    i_valid  = '0;
    i_flit   = '0;
    i_on_off = '1;
    test_reset();
    test_unicast();
    test_contention();
    test_stall();
    test_headtail_rr();
    test_reset_mid();
    test_xy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
